// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter with a single outstanding
// access. Word loads/stores complete in one cycle; byte/halfword stores use a
// read-modify-write pass through the RMW state.
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin arbitration on
// simultaneous requests; when undefined requester 0 always wins.
module dmem_arbiter #(
  parameter int ADDR_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0: core LSU
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [2:0]  req0_size,
  input  logic [31:0] req0_wdata,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,
  // requester 1: loader / debug
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [2:0]  req1_size,
  input  logic [31:0] req1_wdata,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,
  // memory port
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic [3:0]  mem_write_mask,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, RMW, RESP} state_t;

  localparam logic [31:0] WORDS_LIM = 32'(ADDR_WORDS);
  localparam logic [31:0] RO_WORDS  = 32'd32;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;          // requester owning the current access
  logic [29:0] word_q, word_d;        // latched word index
  logic [1:0]  lane_q, lane_d;        // latched addr[1:0]
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;        // word read at accept (load data or RMW old word)
  logic [15:0] wdata_q, wdata_d;      // store bytes kept for the RMW pass
`ifdef DMEM_ARB_RR_EN
  logic        rr_q, rr_d;            // requester that wins the next tie
`endif

  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [2:0]  sel_size;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic        ready0_c, ready1_c, wen_c;
  logic [31:0] mem_wdata_c, mem_addr_c;
  logic [31:0] load_val;

  // Replace the addressed byte/halfword lanes of the old word with store data.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [15:0] wd,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  size);
    logic [31:0] base;
    logic [4:0]  shamt;
    base  = size[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    shamt = {lane, 3'b000};
    return (old_w & ~(base << shamt)) | (({16'h0000, wd} & base) << shamt);
  endfunction

  // Select the addressed lane and sign/zero-extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  size);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    case (size[1:0])
      2'b00:   return {{24{~size[2] & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{~size[2] & sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Next-state, grant and memory-port logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    gnt_d       = gnt_q;
    word_d      = word_q;
    lane_d      = lane_q;
    size_d      = size_q;
    we_d        = we_q;
    err_d       = err_q;
    data_d      = data_q;
    wdata_d     = wdata_q;
`ifdef DMEM_ARB_RR_EN
    rr_d        = rr_q;
`endif
    ready0_c    = 1'b0;
    ready1_c    = 1'b0;
    wen_c       = 1'b0;
    mem_wdata_c = 32'h0;
    mem_addr_c  = {2'b00, word_q};

    if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_RR_EN
      sel = rr_q;
`else
      sel = 1'b0;
`endif
    end else begin
      sel = req1_valid && !req0_valid;
    end

    sel_we    = sel ? req1_we    : req0_we;
    sel_addr  = sel ? req1_addr  : req0_addr;
    sel_size  = sel ? req1_size  : req0_size;
    sel_wdata = sel ? req1_wdata : req0_wdata;

    sel_err = (sel_size == 3'b011) || (sel_size[2:1] == 2'b11)
           || ((sel_size[1:0] == 2'b01) && sel_addr[0])
           || ((sel_size[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00))
           || ({2'b00, sel_addr[31:2]} >= WORDS_LIM)
           || (sel_we && ({2'b00, sel_addr[31:2]} < RO_WORDS));

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          ready0_c   = !sel;
          ready1_c   = sel;
          mem_addr_c = {2'b00, sel_addr[31:2]};
          gnt_d      = sel;
          word_d     = sel_addr[31:2];
          lane_d     = sel_addr[1:0];
          size_d     = sel_size;
          we_d       = sel_we;
          err_d      = sel_err;
          data_d     = mem_read_data;
          wdata_d    = sel_wdata[15:0];
`ifdef DMEM_ARB_RR_EN
          rr_d       = !sel;
`endif
          if (!sel_err && sel_we && (sel_size[1:0] == 2'b10)) begin
            wen_c       = 1'b1;
            mem_wdata_c = sel_wdata;
            state_d     = RESP;
          end else if (!sel_err && sel_we) begin
            state_d = RMW;
          end else begin
            state_d = RESP;
          end
        end
      end
      RMW: begin
        wen_c       = 1'b1;
        mem_wdata_c = merge_word(data_q, wdata_q, lane_q, size_q);
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Access state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      word_q  <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      we_q    <= we_d;
      err_q   <= err_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin tie-break pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Combinational IDLE outputs are gated by reset so they drop the moment reset asserts.
  assign req0_ready       = rst_n & ready0_c;
  assign req1_ready       = rst_n & ready1_c;
  assign mem_write_enable = rst_n & wen_c;
  assign mem_write_data   = mem_wdata_c;
  assign mem_address      = mem_addr_c;
  assign mem_write_mask   = 4'hF;

  assign load_val    = (!we_q && !err_q) ? extract_load(data_q, lane_q, size_q) : 32'h0;
  assign resp0_valid = (state_q == RESP) && !gnt_q;
  assign resp1_valid = (state_q == RESP) && gnt_q;
  assign resp0_err   = resp0_valid && err_q;
  assign resp1_err   = resp1_valid && err_q;
  assign resp0_rdata = resp0_valid ? load_val : 32'h0;
  assign resp1_rdata = resp1_valid ? load_val : 32'h0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WORDS, default 1024, giving the number of 32-bit words in the data memory.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port reqN_valid, input, 1 bit, for N in {0,1}: requester N has a request (N=0 core LSU, N=1 loader/debug).
REQ-005 SHALL have port reqN_ready, output, 1 bit: request accepted this cycle.
REQ-006 SHALL have port reqN_we, input, 1 bit: 1 store, 0 load.
REQ-007 SHALL have port reqN_addr, input, 32 bits: byte address.
REQ-008 SHALL have port reqN_size, input, 3 bits: funct3 encoding; 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port reqN_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port respN_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port respN_rdata, output, 32 bits: aligned, extended load data; 0 for stores.
REQ-012 SHALL have port respN_err, output, 1 bit: misaligned, out-of-range or illegal access.
REQ-013 SHALL have port mem_address, output, 32 bits: word index, reqN_addr[31:2].
REQ-014 SHALL have port mem_write_data, output, 32 bits: full merged word.
REQ-015 SHALL have port mem_write_enable, output, 1 bit: memory write strobe.
REQ-016 SHALL have port mem_write_mask, output, 4 bits: driven constant 4'hF.
REQ-017 SHALL have port mem_read_data, input, 32 bits: combinational memory read of mem_address.

Function
REQ-018 SHALL implement states IDLE, RMW, RESP.
REQ-019 In IDLE, SHALL grant one valid requester and assert only that reqN_ready combinationally.
REQ-020 Accept-cycle error checks: H not 2-byte-aligned or W not 4-byte-aligned; word index >= ADDR_WORDS; store to word index < 32 (constant read-only region); size 011/110/111.
REQ-021 An error request SHALL perform no memory write; next state RESP with respN_err=1.
REQ-022 A load SHALL register mem_read_data at the accept edge, then go to RESP; respN_rdata is the lane selected by addr[1:0], sign-extended (B/H) or zero-extended (BU/HU).
REQ-023 A W store SHALL assert mem_write_enable in the accept cycle with mem_write_data=wdata, then go to RESP.
REQ-024 A B/H store SHALL read the word in the accept cycle, go to RMW, and in RMW assert mem_write_enable with the old word's addressed lanes replaced by the store bytes.
REQ-025 RMW SHALL hold the latched address, size and data; reqN_valid/wdata changes after accept SHALL be ignored.
REQ-026 In RESP, respN_valid SHALL be 1 for exactly one cycle to the granted N only, then return to IDLE.
REQ-027 Latency SHALL be: load/W store/error = response 1 cycle after accept; B/H store = 2 cycles.
REQ-028 Both ready outputs SHALL be 0 outside IDLE; one access outstanding at most.
REQ-029 mem_write_enable SHALL be 0 in all other cycles.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force IDLE, all ready/resp/err/mem_write_enable outputs 0, round-robin pointer to 0.
REQ-031 Reset mid-RMW SHALL abandon the write; no partial write occurs after reset.

Configuration
REQ-032 With DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a simultaneous request, the requester not granted last wins; the pointer updates on each grant.
REQ-033 Without DMEM_ARB_RR_EN, requester 0 SHALL always win a simultaneous request.

Verification
REQ-034 req0 SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> mem write word 0x40, resp0_rdata=0xDEADBEEF one cycle after each accept.
REQ-035 Word 0x40=0xDEADBEEF; SB addr 0x101 data 0x55 -> RMW writes 0xDEAD55EF; LB 0x101=0x00000055; LBU 0x103=0x000000DE; LH 0x102=0xFFFFDEAD.
REQ-036 LW addr 0x102; SH addr 0x101; SW addr 0x40 -> each gives resp_err=1, no mem_write_enable pulse.
REQ-037 Both requesters valid for 4 requests -> with RR_EN grants 0,1,0,1; without RR_EN grants 0,0,0,0.
REQ-038 rst_n low during RMW of SB 0x105 -> no write; word 0x41 unchanged; outputs 0 immediately.
